// File: rtl/mult_share_arb.sv
// Round-robin sharing of a single 16x16 mult_32 between two requesters.
// Latches the winner's operands, pulses init, waits for a done rising edge or watchdog, returns per port.
`timescale 1ns/1ps
module mult_share_arb #(
    parameter int TIMEOUT = 32'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] res0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] res1,
    output logic        m_init,
    output logic [15:0] m_A,
    output logic [15:0] m_B,
    input  logic [31:0] m_pp,
    input  logic        m_done,
    output logic        busy,
    output logic        owner
);

    localparam int WD_W = $clog2(TIMEOUT + 32'd1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 32'd1);
    localparam logic [WD_W-1:0] WD_STEP = WD_W'(32'd1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]      state_r;
    logic            pref_r;
    logic            owner_r;
    logic            busy_r;
    logic            m_init_r;
    logic [15:0]     m_a_r;
    logic [15:0]     m_b_r;
    logic [WD_W-1:0] wd_r;
    logic            d_prev_r;
    logic            ack0_r;
    logic            ack1_r;
    logic            err0_r;
    logic            err1_r;
    logic [31:0]     res0_r;
    logic [31:0]     res1_r;

    logic            grant_s;
    logic            win_s;
    logic            done_edge_s;
    logic            wd_expired_s;
    logic            finish_s;
    logic            timeout_s;

    // Arbitration and completion decode; pref_r names the port that wins a tie.
    always_comb begin
        grant_s      = req0 | req1;
        done_edge_s  = m_done & ~d_prev_r;
        wd_expired_s = (wd_r == WD_LAST);
        finish_s     = (state_r == S_WAIT) & (done_edge_s | wd_expired_s);
        timeout_s    = (state_r == S_WAIT) & ~done_edge_s & wd_expired_s;
        if (req0 && req1) begin
            win_s = pref_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Control FSM: grant, single-cycle init, wait, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            pref_r   <= 1'b0;
            owner_r  <= 1'b0;
            busy_r   <= 1'b0;
            m_init_r <= 1'b0;
        end else begin
            m_init_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (grant_s) begin
                        owner_r  <= win_s;
                        busy_r   <= 1'b1;
                        m_init_r <= 1'b1;
                        state_r  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state_r <= S_WAIT;
                S_WAIT: begin
                    if (finish_s) begin
                        state_r <= S_RESP;
                    end
                end
                S_RESP: begin
                    pref_r  <= ~owner_r;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Operand latch: captured at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_a_r <= 16'd0;
            m_b_r <= 16'd0;
        end else if ((state_r == S_IDLE) && grant_s) begin
            m_a_r <= win_s ? a1 : a0;
            m_b_r <= win_s ? b1 : b0;
        end
    end

    // Watchdog and done history; a done already high on WAIT entry is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_r     <= '0;
            d_prev_r <= 1'b0;
        end else begin
            d_prev_r <= m_done;
            if (state_r == S_LAUNCH) begin
                wd_r <= '0;
            end else if ((state_r == S_WAIT) && !wd_expired_s) begin
                wd_r <= wd_r + WD_STEP;
            end
        end
    end

    // Per-port result, error and ack; ack is high during the RESP cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            err0_r <= 1'b0;
            err1_r <= 1'b0;
            res0_r <= 32'd0;
            res1_r <= 32'd0;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            if (finish_s) begin
                if (owner_r) begin
                    ack1_r <= 1'b1;
                    err1_r <= timeout_s;
                    res1_r <= timeout_s ? 32'd0 : m_pp;
                end else begin
                    ack0_r <= 1'b1;
                    err0_r <= timeout_s;
                    res0_r <= timeout_s ? 32'd0 : m_pp;
                end
            end
        end
    end

    assign ack0   = ack0_r;
    assign ack1   = ack1_r;
    assign err0   = err0_r;
    assign err1   = err1_r;
    assign res0   = res0_r;
    assign res1   = res1_r;
    assign m_init = m_init_r;
    assign m_A    = m_a_r;
    assign m_B    = m_b_r;
    assign busy   = busy_r;
    assign owner  = owner_r;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb with an in-bench multiplier model (configurable latency, optional hang).
`timescale 1ns/1ps
module tb_mult_share_arb;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = 16'd0, b0 = 16'd0, a1 = 16'd0, b1 = 16'd0;
    logic ack0, err0, ack1, err1, m_init, busy, owner;
    logic [31:0] res0, res1;
    logic [15:0] m_A, m_B;
    logic [31:0] m_pp = 32'd0;
    logic m_done = 1'b0;

    always #10 clk = ~clk;

    mult_share_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .err0(err0), .res0(res0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .err1(err1), .res1(res1),
        .m_init(m_init), .m_A(m_A), .m_B(m_B), .m_pp(m_pp), .m_done(m_done),
        .busy(busy), .owner(owner)
    );

    // Multiplier model: done drops on init, rises mult_lat edges later and stays high.
    int mult_lat = 17;
    bit hang = 1'b0;
    int m_cnt = 0;
    logic [15:0] opa = 16'd0, opb = 16'd0;
    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0; m_pp <= 32'd0; m_cnt <= 0;
        end else if (m_init) begin
            m_done <= 1'b0; m_cnt <= mult_lat; opa <= m_A; opb <= m_B;
        end else if (m_cnt == 1 && !hang) begin
            m_done <= 1'b1; m_pp <= {16'd0, opa} * {16'd0, opb}; m_cnt <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end
    end

    int total = 0, bad = 0;
    bit pref_m;
    logic [31:0] exp_res [2];
    logic exp_err [2];

    typedef struct {
        int          port;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        return {16'd0, a} * {16'd0, b};
    endfunction

    task automatic model_reset();
        pref_m = 1'b0;
        exp_res[0] = 32'd0; exp_res[1] = 32'd0;
        exp_err[0] = 1'b0;  exp_err[1] = 1'b0;
    endtask

    task automatic set_ops(input int p, input logic [15:0] a, input logic [15:0] b);
        if (p == 0) begin a0 = a; b0 = b; end else begin a1 = a; b1 = b; end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) req0 = r; else req1 = r;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One request on port p; exp_edges counts edges from request to the visible ack.
    task automatic single_op(input int p, input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] exp_r, input logic exp_e,
                             input int exp_edges, input string tag);
        int edges = 0, inits = 0;
        bit seen = 1'b0, wrong = 1'b0, ack_p, ack_o;
        int o = 1 - p;
        set_ops(p, a, b);
        set_req(p, 1'b1);
        while (!seen && edges < 300) begin
            tick();
            edges++;
            ack_p = (p == 0) ? ack0 : ack1;
            ack_o = (p == 0) ? ack1 : ack0;
            if (m_init) inits++;
            if (ack_o) wrong = 1'b1;
            if (ack_p) seen = 1'b1;
        end
        set_req(p, 1'b0);
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_init_cycles"}, inits, 32'd1);
        check({tag, "_res"}, (p == 0) ? res0 : res1, exp_r);
        check({tag, "_err"}, 32'((p == 0) ? err0 : err1), 32'(exp_e));
        check({tag, "_owner"}, 32'(owner), p);
        check({tag, "_other_res"}, (o == 0) ? res0 : res1, exp_res[o]);
        check({tag, "_other_err"}, 32'((o == 0) ? err0 : err1), 32'(exp_err[o]));
        check({tag, "_other_ack"}, 32'(wrong), 32'd0);
        exp_res[p] = exp_r;
        exp_err[p] = exp_e;
        pref_m = (p == 0);
        tick();
        check({tag, "_ack_pulse"}, 32'((p == 0) ? ack0 : ack1), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Both ports request together with n0/n1 operations each, operands held throughout.
    task automatic run_group(input int n0, input int n1, input string tag);
        int order [$];
        int left [2];
        int acks = 0, edges = 0, w, p, nops;
        bit pp, dbl = 1'b0;
        logic [15:0] ga [2];
        logic [15:0] gb [2];
        ga[0] = a0; gb[0] = b0; ga[1] = a1; gb[1] = b1;
        left[0] = n0; left[1] = n1; pp = pref_m;
        while (left[0] > 0 || left[1] > 0) begin
            if (left[0] > 0 && left[1] > 0) w = pp ? 1 : 0;
            else w = (left[1] > 0) ? 1 : 0;
            order.push_back(w);
            left[w]--;
            pp = (w == 0);
        end
        nops = n0 + n1;
        left[0] = n0; left[1] = n1;
        req0 = (n0 > 0); req1 = (n1 > 0);
        while (acks < nops && edges < nops * (mult_lat + 12) + 40) begin
            tick();
            edges++;
            if (ack0 && ack1) dbl = 1'b1;
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
                check($sformatf("%s_order%0d", tag, acks), p, order[acks]);
                check($sformatf("%s_owner%0d", tag, acks), 32'(owner), p);
                check($sformatf("%s_res%0d", tag, acks), (p == 0) ? res0 : res1, prod(ga[p], gb[p]));
                check($sformatf("%s_err%0d", tag, acks), 32'((p == 0) ? err0 : err1), 32'd0);
                left[p]--;
                if (left[p] == 0) set_req(p, 1'b0);
                exp_res[p] = prod(ga[p], gb[p]);
                exp_err[p] = 1'b0;
                pref_m = (p == 0);
                acks++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check({tag, "_ack_count"}, acks, nops);
        check({tag, "_dual_ack"}, 32'(dbl), 32'd0);
        tick();
    endtask

    initial begin
        logic [15:0] ra, rb, rc, rd;
        int mode;
        vecs[0] = '{0, 16'h0005, 16'h0003, 32'h0000000F};
        vecs[1] = '{1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{0, 16'h0000, 16'h1234, 32'h00000000};
        vecs[3] = '{1, 16'h1234, 16'h0010, 32'h00012340};

        do_reset();
        check("rst_outs", {res0 | res1}, 32'd0);
        check("rst_flags", 32'({ack0, ack1, err0, err1, busy, m_init, owner}), 32'd0);
        check("rst_operands", {m_A, m_B}, 32'd0);

        // Table: single products, extremes and zero operand
        mult_lat = 17;
        for (int i = 0; i < 4; i++)
            single_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 20,
                      $sformatf("vec%0d", i));

        // Minimum latency with the fastest multiplier
        mult_lat = 1;
        single_op(0, 16'd6, 16'd7, 32'd42, 1'b0, 4, "minlat");

        // Tie straight after reset, then fairness over four held operations
        do_reset();
        mult_lat = 5;
        set_ops(0, 16'd7, 16'd9);
        set_ops(1, 16'h0100, 16'h0100);
        run_group(1, 1, "tie");
        check("tie_res0", res0, 32'h0000003F);
        check("tie_res1", res1, 32'h00010000);
        set_ops(0, 16'd11, 16'd13);
        set_ops(1, 16'd300, 16'd200);
        run_group(2, 2, "fair");

        // Hung multiplier: watchdog aborts, then a normal request still works
        hang = 1'b1;
        single_op(0, 16'd9, 16'd9, 32'd0, 1'b1, TIMEOUT + 2, "timeout");
        hang = 1'b0;
        mult_lat = 17;
        single_op(0, 16'd9, 16'd9, 32'd81, 1'b0, 20, "after_to");

        // Reset during WAIT: silent abort, then a fresh request on port 1
        mult_lat = 30;
        set_ops(0, 16'd100, 16'd100);
        req0 = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("midwait_busy", 32'(busy), 32'd1);
        rst = 1'b1; req0 = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        check("midrst_flags", 32'({ack0, ack1, err0, err1, busy, m_init, owner}), 32'd0);
        check("midrst_res", {res0 | res1}, 32'd0);
        check("midrst_operands", {m_A, m_B}, 32'd0);
        begin
            bit any_ack = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ack0 || ack1 || busy) any_ack = 1'b1;
            end
            check("midrst_silent", 32'(any_ack), 32'd0);
        end
        mult_lat = 17;
        single_op(1, 16'd3, 16'd4, 32'h0000000C, 1'b0, 20, "post_rst");

        // Randomized rounds against the bench's own model
        for (int r = 0; r < 20; r++) begin
            mult_lat = $urandom_range(1, 30);
            mode = $urandom_range(0, 2);
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 16'($urandom); rd = 16'($urandom);
            if (mode == 2) begin
                set_ops(0, ra, rb);
                set_ops(1, rc, rd);
                run_group(1, 1, $sformatf("rnd%0d", r));
            end else begin
                single_op(mode, ra, rb, prod(ra, rb), 1'b0, mult_lat + 3,
                          $sformatf("rnd%0d", r));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
